sigmoid_collect: RTL and testbench

Downstream stage of the `array_prod` dot-product unit. It captures each finished dot product, applies a 3-stage pipelined PLAN piecewise-linear sigmoid in QN.QM fixed point, and packs HIDDEN_SZ consecutive activations into a layer vector that the next `array_prod` pass consumes as its input vector. It also emits each scalar activation for per-neuron inspection.

---
 rtl/rnn_fixed_pkg.sv | 48 ++++
 rtl/plan_sigmoid.sv | 71 +++++++
 rtl/sigmoid_collect.sv | 71 +++++++
 tb/tb_sigmoid_collect.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rnn_fixed_pkg.sv
// Shared QN.QM fixed-point constants and helpers for the activation stages
// (PLAN sigmoid today; tanh and friends can reuse the same helpers).
package rnn_fixed_pkg;

   localparam int QN       = 6;
   localparam int QM       = 11;
   localparam int BITWIDTH = QN + QM + 1;

   // PLAN breakpoints/offsets as functions of QM; all exact integers for QM >= 5.
   function automatic int plan_one(input int qm);
      return 1 << qm;
   endfunction

   function automatic int plan_thr_sat(input int qm);
      return 5 << qm;
   endfunction

   function automatic int plan_thr_mid(input int qm);
      return 19 << (qm - 3);
   endfunction

   function automatic int plan_off_hi(input int qm);
      return 27 << (qm - 5);
   endfunction

   function automatic int plan_off_mid(input int qm);
      return 5 << (qm - 3);
   endfunction

   function automatic int plan_off_lo(input int qm);
      return 1 << (qm - 1);
   endfunction

   localparam int ONE = 1 << QM;

   // |x| for a w-bit two's complement value carried in 64 bits; the most
   // negative code has no positive twin, so it clamps to the largest positive.
   function automatic logic signed [63:0] sat_abs(input logic signed [63:0] x, input int w);
      logic signed [63:0] max_pos;
      max_pos = (64'sd1 <<< (w - 1)) - 64'sd1;
      if (x >= 64'sd0)
         return x;
      if (x < -max_pos)
         return max_pos;
      return -x;
   endfunction

endpackage

// File: rtl/plan_sigmoid.sv
// Pipelined PLAN sigmoid: S1 saturating abs, S2 segment select, S3 sign fold.
// S3 is combinational off the S2 register so the consumer's register is stage 3.
module plan_sigmoid
   import rnn_fixed_pkg::*;
#(
   parameter int QN       = 6,
   parameter int QM       = 11,
   parameter int BITWIDTH = QN + QM + 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       sample_valid,
   input  logic signed [BITWIDTH-1:0] sample,
   output logic                       act_valid,
   output logic        [BITWIDTH-1:0] act
);

   localparam logic [BITWIDTH-1:0] ONE_V   = BITWIDTH'(plan_one(QM));
   localparam logic [BITWIDTH-1:0] THR_SAT = BITWIDTH'(plan_thr_sat(QM));
   localparam logic [BITWIDTH-1:0] THR_MID = BITWIDTH'(plan_thr_mid(QM));
   localparam logic [BITWIDTH-1:0] OFF_HI  = BITWIDTH'(plan_off_hi(QM));
   localparam logic [BITWIDTH-1:0] OFF_MID = BITWIDTH'(plan_off_mid(QM));
   localparam logic [BITWIDTH-1:0] OFF_LO  = BITWIDTH'(plan_off_lo(QM));

   logic                s1_valid, s1_sign;
   logic [BITWIDTH-1:0] s1_mag;
   logic                s2_valid, s2_sign;
   logic [BITWIDTH-1:0] s2_y;
   logic signed [63:0]  mag_wide;
   logic [BITWIDTH-1:0] y_next;

   always_comb begin
      mag_wide = sat_abs(64'(sample), BITWIDTH);
   end

   // Magnitude is non-negative, so plain shifts match the arithmetic ones.
   always_comb begin
      y_next = ONE_V;
      if (s1_mag >= THR_SAT)
         y_next = ONE_V;
      else if (s1_mag >= THR_MID)
         y_next = (s1_mag >> 5) + OFF_HI;
      else if (s1_mag >= ONE_V)
         y_next = (s1_mag >> 3) + OFF_MID;
      else
         y_next = (s1_mag >> 2) + OFF_LO;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_mag   <= '0;
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_y     <= '0;
      end else begin
         s1_valid <= sample_valid;
         s1_sign  <= sample[BITWIDTH-1];
         s1_mag   <= BITWIDTH'(mag_wide);
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_y     <= y_next;
      end
   end

   // y never exceeds ONE, so the fold stays in [0, ONE].
   assign act       = s2_sign ? (ONE_V - s2_y) : s2_y;
   assign act_valid = s2_valid;

endmodule

// File: rtl/sigmoid_collect.sv
// Captures array_prod dot products on the dataReady rising edge, runs them
// through the PLAN sigmoid and packs HIDDEN_SZ activations into a layer vector.
module sigmoid_collect
   import rnn_fixed_pkg::*;
#(
   parameter int HIDDEN_SZ      = 8,
   parameter int QN             = 6,
   parameter int QM             = 11,
   parameter int BITWIDTH       = QN + QM + 1,
   parameter int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ,
   parameter int ADDR_BITWIDTH  = $clog2(HIDDEN_SZ)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      dataReadyIn,
   input  logic [BITWIDTH-1:0]       dataIn,
   output logic [BITWIDTH-1:0]       actOut,
   output logic                      actValid,
   output logic [LAYER_BITWIDTH-1:0] layerOut,
   output logic                      layerValid,
   output logic [ADDR_BITWIDTH-1:0]  elemIdx
);

   localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(HIDDEN_SZ - 1);

   logic                                prev_ready;
   logic                                accept;
   logic                                res_valid;
   logic [BITWIDTH-1:0]                 res;
   logic [HIDDEN_SZ-1:0][BITWIDTH-1:0]  layer;

   assign accept = dataReadyIn & ~prev_ready;

   plan_sigmoid #(
      .QN       (QN),
      .QM       (QM),
      .BITWIDTH (BITWIDTH)
   ) u_plan (
      .clock        (clock),
      .reset        (reset),
      .sample_valid (accept),
      .sample       (dataIn),
      .act_valid    (res_valid),
      .act          (res)
   );

   // prev_ready resets high so a level already up at reset release is ignored.
   // elemIdx wraps on its own because HIDDEN_SZ is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_ready <= 1'b1;
         actOut     <= '0;
         actValid   <= 1'b0;
         layerValid <= 1'b0;
         layer      <= '0;
         elemIdx    <= '0;
      end else begin
         prev_ready <= dataReadyIn;
         actValid   <= res_valid;
         layerValid <= res_valid && (elemIdx == LAST_IDX);
         if (res_valid) begin
            layer[elemIdx] <= res;
            actOut         <= res;
            elemIdx        <= elemIdx + 1'b1;
         end
      end
   end

   assign layerOut = layer;

endmodule

// File: tb/tb_sigmoid_collect.sv
// Directed bench for sigmoid_collect: single-value table, full layer, held
// level, and reset corner cases, all against hand-computed PLAN results.
module tb_sigmoid_collect;

   localparam int BW = 18;
   localparam int HS = 8;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            dataReadyIn = 1'b0;
   logic [BW-1:0]   dataIn = '0;
   logic [BW-1:0]   actOut;
   logic            actValid;
   logic [BW*HS-1:0] layerOut;
   logic            layerValid;
   logic [2:0]      elemIdx;

   sigmoid_collect dut (
      .clock       (clock),
      .reset       (reset),
      .dataReadyIn (dataReadyIn),
      .dataIn      (dataIn),
      .actOut      (actOut),
      .actValid    (actValid),
      .layerOut    (layerOut),
      .layerValid  (layerValid),
      .elemIdx     (elemIdx)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [BW-1:0] din;
      logic [BW-1:0] exp_act;
   } vec_t;

   vec_t vecs [HS];
   int   checks = 0;
   int   errors = 0;
   int   act_cnt = 0;
   int   lay_cnt = 0;
   int   act_at_layer = 0;

   always @(negedge clock) begin
      if (actValid) act_cnt = act_cnt + 1;
      if (layerValid) begin
         lay_cnt      = lay_cnt + 1;
         act_at_layer = act_cnt;
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic pulse(input logic [BW-1:0] v);
      dataReadyIn = 1'b1;
      dataIn      = v;
      tick(1);
      dataReadyIn = 1'b0;
      tick(1);
   endtask

   function automatic logic [BW-1:0] slot(input int i);
      return layerOut[i*BW +: BW];
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{18'd0,         18'd1024};
      vecs[1] = '{18'd2048,      18'd1536};
      vecs[2] = '{18'(-2048),    18'd512};
      vecs[3] = '{18'd4864,      18'd1880};
      vecs[4] = '{18'd1000,      18'd1274};
      vecs[5] = '{18'd10240,     18'd2048};
      vecs[6] = '{18'h20000,     18'd0};
      vecs[7] = '{18'd0,         18'd1024};

      // Reset state, with the ready level already high during reset.
      dataReadyIn = 1'b1;
      tick(3);
      chk("rst_actOut", 64'(actOut), 0);
      chk("rst_actValid", 64'(actValid), 0);
      chk("rst_layerValid", 64'(layerValid), 0);
      chk("rst_layerOut", 64'(layerOut != '0), 0);
      chk("rst_elemIdx", 64'(elemIdx), 0);
      reset = 1'b0;
      tick(6);
      #1;
      chk("held_level_at_release", 64'(act_cnt), 0);
      dataReadyIn = 1'b0;
      tick(2);

      // Single values: accept at edge 1, outputs visible after edge 3.
      for (int i = 0; i < HS - 1; i++) begin
         dataReadyIn = 1'b1;
         dataIn      = vecs[i].din;
         tick(1);
         dataReadyIn = 1'b0;
         tick(1);
         chk($sformatf("single%0d_early", i), 64'(actValid), 0);
         tick(1);
         chk($sformatf("single%0d_valid", i), 64'(actValid), 1);
         chk($sformatf("single%0d_act", i), 64'(actOut), 64'(vecs[i].exp_act));
         chk($sformatf("single%0d_idx", i), 64'(elemIdx), 64'(i + 1));
         tick(1);
         chk($sformatf("single%0d_pulse1", i), 64'(actValid), 0);
      end

      // Full layer, one sample every 2 cycles.
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
      #1;
      act_cnt = 0;
      lay_cnt = 0;
      for (int i = 0; i < HS; i++) pulse(vecs[i].din);
      tick(4);
      #1;
      chk("layer_pulses", 64'(lay_cnt), 1);
      chk("layer_at_8th", 64'(act_at_layer), 8);
      chk("layer_acts", 64'(act_cnt), 8);
      chk("layer_idx_wrap", 64'(elemIdx), 0);
      for (int i = 0; i < HS; i++)
         chk($sformatf("layer_slot%0d", i), 64'(slot(i)), 64'(vecs[i].exp_act));

      // Held-high level accepts once.
      act_cnt = 0;
      dataReadyIn = 1'b1;
      dataIn      = 18'd2048;
      tick(20);
      dataReadyIn = 1'b0;
      tick(4);
      #1;
      chk("hold_acts", 64'(act_cnt), 1);
      chk("hold_idx", 64'(elemIdx), 1);
      chk("hold_slot0", 64'(slot(0)), 1536);
      chk("hold_slot1_prev_layer", 64'(slot(1)), 1536);

      // Reset after 5 of 8 samples discards the partial layer.
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(1);
      for (int i = 0; i < 5; i++) pulse(18'd2048);
      tick(4);
      chk("partial_idx", 64'(elemIdx), 5);
      #1;
      lay_cnt = 0;
      reset = 1'b1;
      tick(1);
      chk("partial_rst_idx", 64'(elemIdx), 0);
      chk("partial_rst_layer", 64'(layerOut != '0), 0);
      reset = 1'b0;
      tick(1);
      #1;
      act_cnt = 0;
      pulse(18'd1000);
      tick(3);
      #1;
      chk("after_rst_acts", 64'(act_cnt), 1);
      chk("after_rst_idx", 64'(elemIdx), 1);
      chk("after_rst_slot0", 64'(slot(0)), 1274);
      chk("after_rst_slot1", 64'(slot(1)), 0);
      chk("after_rst_no_layer", 64'(lay_cnt), 0);

      // Reset landing on the cycle S3 would write.
      dataReadyIn = 1'b1;
      dataIn      = 18'd4864;
      tick(1);
      dataReadyIn = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(1);
      chk("s3rst_actValid", 64'(actValid), 0);
      chk("s3rst_actOut", 64'(actOut), 0);
      chk("s3rst_idx", 64'(elemIdx), 0);
      chk("s3rst_layer", 64'(layerOut != '0), 0);
      reset = 1'b0;
      tick(4);
      #1;
      chk("s3rst_no_pulse", 64'(act_cnt), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
